// File: rtl/des_pkg.sv
// Shared DES constants: widths, FSM encoding, PC1/PC2 tables, shift schedule
// and the small bit-manipulation helpers used by the key scheduler.
package des_pkg;

    localparam int unsigned KEY_W      = 64;
    localparam int unsigned PC1_W      = 56;
    localparam int unsigned CD_W       = 28;
    localparam int unsigned SUBKEY_W   = 48;
    localparam int unsigned ROUND_W    = 5;
    localparam int unsigned NUM_ROUNDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_PERM = 2'd2,
        ST_EMIT = 2'd3
    } state_e;

    // One presented subkey together with its round number.
    typedef struct packed {
        logic [ROUND_W-1:0]  round_id;
        logic [SUBKEY_W-1:0] subkey;
    } subkey_beat_t;

    // Entries are 1-based DES bit numbers, bit 1 = MSB.
    localparam int unsigned PC1_TAB [PC1_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TAB [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Shift amount for a 1-based round number; out-of-range wraps harmlessly.
    function automatic logic [1:0] shift_amt(input logic [ROUND_W-1:0] round);
        logic [3:0] idx;
        idx = 4'(round - 5'd1);
        return SHIFT_TAB[idx];
    endfunction

    function automatic logic [PC1_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [PC1_W-1:0] r;
        r = '0;
        for (int j = 0; j < int'(PC1_W); j++) begin
            r[6'(PC1_W - 1 - j)] = k[6'(KEY_W - PC1_TAB[j])];
        end
        return r;
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Every key byte must carry odd parity.
    function automatic logic odd_parity_ok(input logic [KEY_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ok = ok & (^k[8*i +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// DES PC2 compression permutation, 56-bit {C,D} -> 48-bit round subkey.
// Purely combinational.
//   cd  : {C,D}, DES bit 1 = MSB
//   k_c : 48-bit subkey, DES bit 1 = MSB
module des_pc2_perm
    import des_pkg::*;
(
    input  logic [PC1_W-1:0]    cd,
    output logic [SUBKEY_W-1:0] k_c
);

    always_comb begin
        k_c = '0;
        for (int j = 0; j < int'(SUBKEY_W); j++) begin
            k_c[6'(SUBKEY_W - 1 - j)] = cd[6'(PC1_W - PC2_TAB[j])];
        end
    end

endmodule

// File: rtl/des_key_schedule_stream.sv
// Sequential DES key scheduler: accepts one 64-bit key and streams the 16
// round subkeys over a valid/ready handshake, rotating C/D incrementally
// (left for encrypt K1..K16, right for decrypt K16..K1).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, decrypt, keyIn request, direction and key (sampled in IDLE)
//   subkey, round_id      current subkey and its round number
//   subkey_valid/_ready   output handshake
//   busy, done            stream in progress / one-cycle completion pulse
//   key_err               key parity failure (PARITY_CHECK_EN builds only)
// Build option: define PARITY_CHECK_EN to reject keys with even-parity bytes.
module des_key_schedule_stream
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                decrypt,
    input  logic [KEY_W-1:0]    keyIn,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [ROUND_W-1:0]  round_id,
    output logic                busy,
    output logic                done,
    output logic                key_err
);

    state_e              state_q, state_d;
    logic [CD_W-1:0]     c_q, c_d;
    logic [CD_W-1:0]     d_q, d_d;
    logic                dec_q, dec_d;
    subkey_beat_t        beat_q, beat_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                key_err_q, key_err_d;

    logic [PC1_W-1:0]    pc1_c;
    logic [SUBKEY_W-1:0] pc2_c;
    logic [1:0]          shift_c;
    logic                key_ok_c;
    logic                last_c;

    assign pc1_c = pc1(keyIn);

`ifdef PARITY_CHECK_EN
    assign key_ok_c = odd_parity_ok(keyIn);
`else
    assign key_ok_c = 1'b1;
`endif

    // Decrypt undoes the shift that produced the next-higher round.
    assign shift_c = dec_q ? shift_amt(beat_q.round_id + 5'd1) : shift_amt(beat_q.round_id);
    assign last_c  = dec_q ? (beat_q.round_id == 5'd1) : (beat_q.round_id == 5'd16);

    des_pc2_perm u_pc2 (
        .cd  ({c_q, d_q}),
        .k_c (pc2_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            d_q       <= '0;
            dec_q     <= 1'b0;
            beat_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            dec_q     <= dec_d;
            beat_q    <= beat_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            key_err_q <= key_err_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        dec_d     = dec_q;
        beat_d    = beat_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        key_err_d = key_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (key_ok_c) begin
                        c_d             = pc1_c[PC1_W-1:CD_W];
                        d_d             = pc1_c[CD_W-1:0];
                        dec_d           = decrypt;
                        busy_d          = 1'b1;
                        key_err_d       = 1'b0;
                        beat_d.round_id = decrypt ? 5'd16 : 5'd1;
                        state_d         = ST_ROT;
                    end else begin
                        key_err_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_ROT: begin
                // Round 16 in decrypt uses the unrotated C0/D0 (total shift is 28).
                if (!dec_q) begin
                    c_d = rotl28(c_q, shift_c);
                    d_d = rotl28(d_q, shift_c);
                end else if (beat_q.round_id != 5'd16) begin
                    c_d = rotr28(c_q, shift_c);
                    d_d = rotr28(d_q, shift_c);
                end
                state_d = ST_PERM;
            end
            ST_PERM: begin
                beat_d.subkey = pc2_c;
                valid_d       = 1'b1;
                state_d       = ST_EMIT;
            end
            ST_EMIT: begin
                if (valid_q && subkey_ready) begin
                    valid_d = 1'b0;
                    if (last_c) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d.round_id = dec_q ? (beat_q.round_id - 5'd1)
                                                : (beat_q.round_id + 5'd1);
                        state_d = ST_ROT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign subkey       = beat_q.subkey;
    assign round_id     = beat_q.round_id;
    assign subkey_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign key_err      = key_err_q;

endmodule
